// File: rtl/haar_stage_evaluator.sv
// haar_stage_evaluator
//
// Per-window cascade controller for the Haar face detector. It adds up the
// weak-classifier votes of the current stage and compares the sum with the
// stage threshold. A pass moves on to the next stage. A fail rejects the
// window early. It reports one face/no-face verdict per window.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   win_start       starts a new window (honoured only when idle)
//   win_busy        high whenever a window is in flight or its verdict is pending
//   wk_valid/ready  weak-vote handshake; wk_value is a signed Q11.12 leaf value,
//                   wk_last marks the final vote of the stage
//   stage_num       registered stage index driving the threshold lookup
//   stage_thresh    signed Q11.12 threshold for stage_num (combinational lookup)
//   result_valid/ready  verdict handshake
//   result_face     1 = every stage passed
//   result_stage    failing stage, or NUM_STAGES-1 on a face
module haar_stage_evaluator #(
  parameter int unsigned NUM_STAGES = 22,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned STAGE_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               win_start,
  output logic               win_busy,

  input  logic               wk_valid,
  output logic               wk_ready,
  input  logic [DATA_W-1:0]  wk_value,
  input  logic               wk_last,

  output logic [STAGE_W-1:0] stage_num,
  input  logic [DATA_W-1:0]  stage_thresh,

  output logic               result_valid,
  input  logic               result_ready,
  output logic               result_face,
  output logic [STAGE_W-1:0] result_stage
);

  localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StCompare,
    StDone
  } state_e;

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [STAGE_W-1:0]        stage_q;
  logic                      face_q;
  logic [STAGE_W-1:0]        res_stage_q;

  logic signed [ACC_W-1:0]   vote_ext;
  logic signed [ACC_W-1:0]   thresh_ext;
  logic                      vote_fire;
  logic                      stage_pass;

  // Both operands are Q.12; sign extension aligns them without any shift.
  assign vote_ext   = {{(ACC_W - DATA_W){wk_value[DATA_W-1]}}, wk_value};
  assign thresh_ext = {{(ACC_W - DATA_W){stage_thresh[DATA_W-1]}}, stage_thresh};

  assign vote_fire  = (state_q == StAccum) && wk_valid;
  // Equality counts as a pass.
  assign stage_pass = (acc_q >= thresh_ext);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      stage_q     <= '0;
      face_q      <= 1'b0;
      res_stage_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_start) begin
            stage_q <= '0;
            acc_q   <= '0;
            state_q <= StAccum;
          end
        end

        StAccum: begin
          if (vote_fire) begin
            // The worst-case stage sum fits in ACC_W, so no saturation.
            acc_q <= acc_q + vote_ext;
            if (wk_last) begin
              state_q <= StCompare;
            end
          end
        end

        StCompare: begin
          if (stage_pass) begin
            if (stage_q == LastStage) begin
              face_q      <= 1'b1;
              res_stage_q <= stage_q;
              state_q     <= StDone;
            end else begin
              stage_q <= stage_q + 1'b1;
              acc_q   <= '0;
              state_q <= StAccum;
            end
          end else begin
            face_q      <= 1'b0;
            res_stage_q <= stage_q;
            state_q     <= StDone;
          end
        end

        StDone: begin
          // A win_start seen here is dropped, not queued.
          if (result_ready) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Every output is a direct decode of registered state.
  assign win_busy     = (state_q != StIdle);
  assign wk_ready     = (state_q == StAccum);
  assign result_valid = (state_q == StDone);
  assign stage_num    = stage_q;
  assign result_face  = face_q;
  assign result_stage = res_stage_q;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Self-checking bench for haar_stage_evaluator. A table of stage thresholds
// acts as the lookup ROM. Each window is described as a flat list of votes
// with last-of-stage flags. The reference walks that list with plain integer
// sums to decide where the cascade stops and what the verdict is.
module tb_haar_stage_evaluator;

  localparam int NS = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        win_start = 1'b0;
  logic        win_busy;
  logic        wk_valid = 1'b0;
  logic        wk_ready;
  logic [23:0] wk_value = '0;
  logic        wk_last = 1'b0;
  logic [4:0]  stage_num;
  logic [23:0] stage_thresh;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        result_face;
  logic [4:0]  result_stage;

  int thr [NS];
  int q_val[$];
  bit q_last[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign stage_thresh = (int'(stage_num) < NS) ? 24'(thr[stage_num]) : 24'd0;

  haar_stage_evaluator #(
    .NUM_STAGES(NS),
    .DATA_W    (24),
    .ACC_W     (32),
    .STAGE_W   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .win_start   (win_start),
    .win_busy    (win_busy),
    .wk_valid    (wk_valid),
    .wk_ready    (wk_ready),
    .wk_value    (wk_value),
    .wk_last     (wk_last),
    .stage_num   (stage_num),
    .stage_thresh(stage_thresh),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_face (result_face),
    .result_stage(result_stage)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"},     32'(win_busy),     32'd0);
    check_eq({tag, "_ready"},    32'(wk_ready),     32'd0);
    check_eq({tag, "_stage"},    32'(stage_num),    32'd0);
    check_eq({tag, "_rvalid"},   32'(result_valid), 32'd0);
    check_eq({tag, "_rface"},    32'(result_face),  32'd0);
    check_eq({tag, "_rstage"},   32'(result_stage), 32'd0);
  endtask

  task automatic push_vote(input int v, input bit last);
    q_val.push_back(v);
    q_last.push_back(last);
  endtask

  // Drive one window from the vote list. Inputs change and outputs are
  // sampled on the falling edge. hold = cycles the verdict is back-pressured
  // while a stray win_start is pulsed; abort = reset once the list runs out.
  task automatic run_window(input string tag, input int hold, input bit abort);
    int     exp_stage = 0;
    longint acc = 0;
    bit     done = 1'b0;
    bit     face = 1'b0;
    win_start = 1'b1;
    @(negedge clk);
    win_start = 1'b0;
    check_eq({tag, "_start_busy"},  32'(win_busy),  32'd1);
    check_eq({tag, "_start_ready"}, 32'(wk_ready),  32'd1);
    check_eq({tag, "_start_stage"}, 32'(stage_num), 32'd0);
    for (int i = 0; i < q_val.size() && !done; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_eq({tag, "_gap_ready"}, 32'(wk_ready), 32'd1);
      end
      wk_valid = 1'b1;
      wk_value = 24'(q_val[i]);
      wk_last  = q_last[i];
      @(negedge clk);
      wk_valid = 1'b0;
      wk_last  = 1'b0;
      acc += q_val[i];
      if (q_last[i]) begin
        check_eq({tag, "_cmp_ready"},  32'(wk_ready),     32'd0);
        check_eq({tag, "_cmp_rvalid"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_cmp_stage"},  32'(stage_num),    32'(exp_stage));
        @(negedge clk);
        if (acc >= longint'(thr[exp_stage])) begin
          if (exp_stage == NS - 1) begin
            face = 1'b1;
            done = 1'b1;
          end else begin
            exp_stage++;
            acc = 0;
            check_eq({tag, "_next_stage"},  32'(stage_num),    32'(exp_stage));
            check_eq({tag, "_next_ready"},  32'(wk_ready),     32'd1);
            check_eq({tag, "_next_rvalid"}, 32'(result_valid), 32'd0);
          end
        end else begin
          face = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (abort && !done) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset({tag, "_abort"});
    end else begin
      check_eq({tag, "_rvalid"}, 32'(result_valid), 32'd1);
      check_eq({tag, "_rface"},  32'(result_face),  32'(face));
      check_eq({tag, "_rstage"}, 32'(result_stage), 32'(exp_stage));
      check_eq({tag, "_dbusy"},  32'(win_busy),     32'd1);
      check_eq({tag, "_dready"}, 32'(wk_ready),     32'd0);
      for (int k = 0; k < hold; k++) begin
        win_start = (k == 1);
        @(negedge clk);
        win_start = 1'b0;
        check_eq({tag, "_hold_rvalid"}, 32'(result_valid), 32'd1);
        check_eq({tag, "_hold_rface"},  32'(result_face),  32'(face));
        check_eq({tag, "_hold_rstage"}, 32'(result_stage), 32'(exp_stage));
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check_eq({tag, "_idle_rvalid"}, 32'(result_valid), 32'd0);
      check_eq({tag, "_idle_busy"},   32'(win_busy),     32'd0);
      if (hold > 0) begin
        @(negedge clk);
        check_eq({tag, "_no_queued_start"}, 32'(win_busy), 32'd0);
      end
    end
    q_val.delete();
    q_last.delete();
  endtask

  task automatic random_thresholds();
    for (int s = 0; s < NS; s++) begin
      thr[s] = int'($urandom_range(0, 2000000)) - 1000000;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    random_thresholds();
    thr[0] = 3370;

    // Reset state.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("after_reset");

    // Early reject at stage 0: 2048 + 256 < 3370.
    push_vote(2048, 1'b0);
    push_vote(256, 1'b1);
    run_window("early_reject", 0, 1'b0);

    // Equality passes stage 0, then stage 1 fails by one LSB.
    push_vote(3000, 1'b0);
    push_vote(370, 1'b1);
    push_vote(thr[1] - 1, 1'b1);
    run_window("equality", 0, 1'b0);

    // Full cascade: every stage clears its threshold by one.
    for (int s = 0; s < NS; s++) push_vote(thr[s] + 1, 1'b1);
    run_window("full_cascade", 0, 1'b0);

    // Negative votes: sum 4095 passes, then stage 1 fails; sum -1 fails.
    push_vote(-4096, 1'b0);
    push_vote(8192, 1'b0);
    push_vote(-1, 1'b1);
    push_vote(thr[1] - 1, 1'b1);
    run_window("neg_pass", 0, 1'b0);
    push_vote(-4096, 1'b0);
    push_vote(4096, 1'b0);
    push_vote(-1, 1'b1);
    run_window("neg_fail", 0, 1'b0);

    // Back-pressured verdict with a stray start, then a fresh window.
    push_vote(100, 1'b1);
    run_window("backpressure", 5, 1'b0);
    push_vote(3370, 1'b1);
    push_vote(thr[1] - 7, 1'b1);
    run_window("fresh_after_bp", 0, 1'b0);

    // Reset during stage 5 after three votes, then a clean stage-0 reject.
    for (int s = 0; s < 5; s++) push_vote(thr[s] + 1, 1'b1);
    push_vote(100, 1'b0);
    push_vote(-50, 1'b0);
    push_vote(7, 1'b0);
    run_window("mid_reset", 0, 1'b1);
    push_vote(2048, 1'b0);
    push_vote(256, 1'b1);
    run_window("post_reset", 0, 1'b0);

    // Random windows: random thresholds and multi-vote stages that mostly pass.
    for (int w = 0; w < 20; w++) begin
      random_thresholds();
      for (int s = 0; s < NS; s++) begin
        int nv;
        int partial;
        nv = int'($urandom_range(1, 4));
        partial = 0;
        for (int j = 0; j < nv - 1; j++) begin
          int v;
          v = int'($urandom_range(0, 4000)) - 2000;
          partial += v;
          push_vote(v, 1'b0);
        end
        push_vote(thr[s] - partial + int'($urandom_range(0, 40)) - 5, 1'b1);
      end
      run_window("random", int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/haar_stage_evaluator.md
# haar_stage_evaluator

Per-window cascade controller for the Haar face detector. It accumulates the weak-classifier votes of the current stage and compares the stage sum with the stage threshold. On a pass it advances to the next stage; on a fail it rejects the window early. It drives `stage_num` into the stage-threshold lookup, reads back the fixed-point threshold, and reports one face/no-face verdict per window downstream.

## Interface
- `NUM_STAGES`, 22: number of cascade stages.
- `DATA_W`, 24: width of weak votes and thresholds; signed Q11.12.
- `ACC_W`, 32: stage accumulator width; signed Q19.12.
- `STAGE_W`, 5: width of stage index.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `win_start`  in  1  pulse that starts evaluation of a new window; honoured only in IDLE.
- `win_busy`  out  1  high in every state except IDLE.
- `wk_valid`  in  1  weak-classifier vote valid.
- `wk_ready`  out  1  vote accepted when `wk_valid & wk_ready`.
- `wk_value`  in  DATA_W  signed vote (left or right leaf value).
- `wk_last`  in  1  marks the final vote of the current stage.
- `stage_num`  out  STAGE_W  current stage index, registered; drives the threshold lookup.
- `stage_thresh`  in  DATA_W  signed threshold for `stage_num`; combinational from the lookup.
- `result_valid`  out  1  verdict valid.
- `result_ready`  in  1  downstream accepts the verdict.
- `result_face`  out  1  1 = all stages passed.
- `result_stage`  out  STAGE_W  last stage evaluated: the failing stage, or NUM_STAGES-1 on a face.

## Operation
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- **IDLE**
  - `wk_ready`=0.
  - On `win_start`: `stage_num`←0, `acc`←0, go to ACCUM.
- **ACCUM**
  - `wk_ready`=1.
  - On each accepted vote: `acc` ← `acc` + sign-extended `wk_value`. No saturation; ACC_W covers the worst-case stage sum.
  - If the accepted vote has `wk_last`=1: go to COMPARE. `acc` then includes that vote.
- **COMPARE**
  - `wk_ready`=0.
  - Signed compare of `acc` against sign-extended `stage_thresh`.
  - Pass when `acc >= thresh`, including equality:
    - If `stage_num == NUM_STAGES-1`: `result_face`←1, `result_stage`←`stage_num`, go to DONE.
    - Otherwise: `stage_num`←`stage_num`+1, `acc`←0, go to ACCUM.
  - Fail: `result_face`←0, `result_stage`←`stage_num`, go to DONE.
- **DONE**
  - `result_valid`=1; `result_face` and `result_stage` held stable until `result_ready`.
  - On `result_valid & result_ready`: go to IDLE; `result_valid` drops the next cycle.
- `win_start` outside IDLE is ignored; it is not queued.
- The upstream feature engine uses `result_valid` (or `win_busy` falling) to abandon the remaining votes of a rejected window. No vote is consumed outside ACCUM.
- A `wk_valid` that arrives in the same cycle as `win_start` is not accepted, because `wk_ready` is still 0 in IDLE.

## Timing
- Reset values:
  - state IDLE; `acc`=0; `stage_num`=0.
  - `win_busy`=0, `wk_ready`=0.
  - `result_valid`=0, `result_face`=0, `result_stage`=0.
- `win_start` sampled at cycle t: ACCUM and `wk_ready`=1 at t+1.
- Last vote of a stage accepted at cycle t:
  - COMPARE at t+1; `stage_thresh` is sampled that cycle, for the `stage_num` valid since ACCUM.
  - At t+2 the block is either in ACCUM for the next stage (`stage_num` incremented, `wk_ready`=1) or in DONE (`result_valid`=1).
- Per-stage overhead is 1 bubble cycle (COMPARE).
- `stage_num` changes only on the COMPARE→ACCUM transition or on `win_start`. The lookup therefore has a full stage's duration, at least 1 cycle, to settle.
- Reset mid-operation, in any state: returns to the reset values on the next edge; the partial window is discarded and no verdict is produced.
- Back-to-back windows: `result_ready`=1 in DONE at t gives IDLE at t+1. A `win_start` at t+1 gives ACCUM at t+2.

## Test plan
- **Early reject.** Stage-0 thresh 3370 (0.8227). Votes 2048 then 256, with `wk_last` on the second. Required: at t+2, `result_valid`=1, `result_face`=0, `result_stage`=0.
- **Equality pass.** Stage 0, votes 3000 and 370 (`wk_last`). Required: `stage_num`=1, `acc`=0, `wk_ready`=1 two cycles after `wk_last`; no `result_valid`.
- **Full cascade.** Threshold model for all 22 stages. Each stage gets one vote equal to its threshold plus 1, with `wk_last`. Required: `result_face`=1, `result_stage`=21; `stage_num` walks 0..21 with exactly 1 bubble per stage.
- **Negative votes.** Stage 0 votes -4096, 8192, -1 (`wk_last`); sum 4095 ≥ 3370. Required: pass. Repeat with -4096, 4096, -1; sum -1. Required: `result_face`=0.
- **Backpressure and ignored start.**
  - Hold `result_ready`=0 for 5 cycles in DONE and pulse `win_start`. Required: outputs stable and the start ignored.
  - Then `result_ready`=1. Required: IDLE next cycle.
  - A fresh `win_start` then begins at stage 0.
- **Reset mid-window.** Assert `rst_n`=0 during ACCUM at stage 5 after 3 votes. Required: all outputs at reset values the next cycle. A following window rejects correctly at stage 0.
